// File: rtl/calc_stim_checker_pkg.sv
// Shared widths, MODO encodings, FSM states and the stimulus payload for the
// calculadora initiator/checker.
package calc_stim_checker_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned MODO_W = 2;
   localparam int unsigned LFSR_W = 16;
   localparam int unsigned WCNT_W = 3;

   localparam logic [MODO_W-1:0] MODO_SUMA  = 2'b00;
   localparam logic [MODO_W-1:0] MODO_RESTA = 2'b01;
   localparam logic [MODO_W-1:0] MODO_AND   = 2'b10;
   localparam logic [MODO_W-1:0] MODO_OR    = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_WAIT,
      ST_CHECK,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [MODO_W-1:0] modo;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] a;
   } vec_t;

   // Operands and operation for one vector, taken from the LFSR before it steps.
   function automatic vec_t vec_from_lfsr(input logic [LFSR_W-1:0] s);
      vec_t v;
      v.a    = s[7:0];
      v.b    = s[15:8];
      v.modo = s[1:0] ^ s[9:8];
      return v;
   endfunction

endpackage

// File: rtl/calc_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11). A load and a step on the same edge
// yield the seed advanced by one step.
module calc_lfsr16
   import calc_stim_checker_pkg::*;
#(
   parameter logic [LFSR_W-1:0] RST_VAL = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              step,
   output logic [LFSR_W-1:0] q
);

   logic [LFSR_W-1:0] q_q;
   logic [LFSR_W-1:0] q_d;
   logic [LFSR_W-1:0] base_c;

   // Right-shifting form: taps 16,14,13,11 land on bits 0,2,3,5.
   always_comb begin
      base_c = load ? seed : q_q;
      q_d    = base_c;
      if (step) begin
         q_d = {base_c[0] ^ base_c[2] ^ base_c[3] ^ base_c[5], base_c[LFSR_W-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q <= RST_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/calc_stim_checker.sv
// Initiator/checker for the 8-bit calculadora: drives LFSR vectors on a/b/MODO
// with a one-cycle enb, samples c LAT cycles later and counts mismatches.
module calc_stim_checker
   import calc_stim_checker_pkg::*;
#(
   parameter int unsigned       N_VEC = 64,
   parameter int unsigned       LAT   = 1,
   parameter logic [LFSR_W-1:0] SEED  = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] c,
   output logic              enb,
   output logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] b,
   output logic [MODO_W-1:0] MODO,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] err_cnt,
   output logic              pass
);

   localparam logic [DATA_W-1:0] VEC_LAST  = DATA_W'(N_VEC - 1);
   localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(LAT - 1);
   localparam logic [DATA_W-1:0] ERR_MAX   = '1;

   state_e            state_q, state_d;
   vec_t              vec_q, vec_d;
   logic              enb_q, enb_d;
   logic [DATA_W-1:0] exp_q, exp_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [DATA_W-1:0] err_q, err_d;
   logic [DATA_W-1:0] vcnt_q, vcnt_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;

   logic              load_c;
   logic              launch_c;
   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] src_c;
   vec_t              src_vec_c;

   function automatic logic [DATA_W-1:0] golden(input vec_t v);
      logic [DATA_W-1:0] r;
      case (v.modo)
         MODO_SUMA:  r = v.a + v.b;
         MODO_RESTA: r = v.a - v.b;
         MODO_AND:   r = v.a & v.b;
         MODO_OR:    r = v.a | v.b;
         default:    r = '0;
      endcase
      return r;
   endfunction

   calc_lfsr16 #(
      .RST_VAL (SEED)
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (load_c),
      .seed (SEED),
      .step (launch_c),
      .q    (lfsr_q)
   );

   // A (re)start launches the first vector straight from SEED on the same edge.
   assign src_c     = load_c ? SEED : lfsr_q;
   assign src_vec_c = vec_from_lfsr(src_c);

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      enb_d    = 1'b0;
      exp_d    = exp_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;
      err_d    = err_q;
      vcnt_d   = vcnt_q;
      wcnt_d   = wcnt_q;
      load_c   = 1'b0;
      launch_c = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               load_c   = 1'b1;
               launch_c = 1'b1;
               err_d    = '0;
               vcnt_d   = '0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               pass_d   = 1'b0;
               state_d  = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (LAT == 1) begin
               state_d = ST_CHECK;
            end else begin
               wcnt_d  = WAIT_INIT;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Leave as the count reaches zero so WAIT spans LAT-1 cycles.
            wcnt_d = wcnt_q - WCNT_W'(1);
            if (wcnt_q == WCNT_W'(1)) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if ((c != exp_q) && (err_q != ERR_MAX)) begin
               err_d = err_q + DATA_W'(1);
            end
            vcnt_d = vcnt_q + DATA_W'(1);
            if (vcnt_q == VEC_LAST) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
               state_d = ST_DONE;
            end else begin
               launch_c = 1'b1;
               state_d  = ST_DRIVE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (launch_c) begin
         vec_d = src_vec_c;
         enb_d = 1'b1;
         exp_d = golden(src_vec_c);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         vec_q   <= '0;
         enb_q   <= 1'b0;
         exp_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         vcnt_q  <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         enb_q   <= enb_d;
         exp_q   <= exp_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         vcnt_q  <= vcnt_d;
         wcnt_q  <= wcnt_d;
      end
   end

   assign enb     = enb_q;
   assign a       = vec_q.a;
   assign b       = vec_q.b;
   assign MODO    = vec_q.modo;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err_cnt = err_q;
   assign pass    = pass_q;

endmodule

// File: tb/tb_calc_stim_checker.sv
// Directed bench for calc_stim_checker: four instances with different N_VEC/LAT,
// each facing its own calculator model (ideal, MODO 01 broken, 3-stage, stuck-at-0).
module tb_calc_stim_checker;

   logic clk;
   logic rst;
   logic bug;
   logic start1, start3, start5, start7;
   logic [7:0] c1, c3, c5, c7, p1, p2;

   logic enb1, enb3, enb5, enb7;
   logic [7:0] a1, a3, a5, a7, b1, b3, b5, b7;
   logic [1:0] m1, m3, m5, m7;
   logic busy1, busy3, busy5, busy7;
   logic done1, done3, done5, done7;
   logic pass1, pass3, pass5, pass7;
   logic [7:0] err1, err3, err5, err7;

   int n_chk;
   int n_pass;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   calc_stim_checker #(.N_VEC(64), .LAT(1), .SEED(16'hACE1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .c(c1), .enb(enb1), .a(a1), .b(b1),
      .MODO(m1), .busy(busy1), .done(done1), .err_cnt(err1), .pass(pass1));

   calc_stim_checker #(.N_VEC(64), .LAT(3), .SEED(16'hACE1)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .c(c3), .enb(enb3), .a(a3), .b(b3),
      .MODO(m3), .busy(busy3), .done(done3), .err_cnt(err3), .pass(pass3));

   calc_stim_checker #(.N_VEC(255), .LAT(1), .SEED(16'hACE1)) u_dut5 (
      .clk(clk), .rst(rst), .start(start5), .c(c5), .enb(enb5), .a(a5), .b(b5),
      .MODO(m5), .busy(busy5), .done(done5), .err_cnt(err5), .pass(pass5));

   calc_stim_checker #(.N_VEC(1), .LAT(2), .SEED(16'hACE1)) u_dut7 (
      .clk(clk), .rst(rst), .start(start7), .c(c7), .enb(enb7), .a(a7), .b(b7),
      .MODO(m7), .busy(busy7), .done(done7), .err_cnt(err7), .pass(pass7));

   function automatic logic [7:0] calc_ref(input logic [7:0] x, input logic [7:0] y,
                                           input logic [1:0] m);
      if (m == 2'b00) return 8'(x + y);
      else if (m == 2'b01) return 8'(x - y);
      else if (m == 2'b10) return x & y;
      return x | y;
   endfunction

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return (s >> 1) | {fb, 15'd0};
   endfunction

   // Calculator models facing each instance.
   always @(posedge clk) begin
      if (enb1) c1 <= (bug && m1 == 2'b01) ? 8'(a1 + b1) : calc_ref(a1, b1, m1);
      p1 <= calc_ref(a3, b3, m3);
      p2 <= p1;
      c3 <= p2;
      c7 <= calc_ref(a7, b7, m7);
   end
   assign c5 = 8'h00;

   int         sel;
   logic       s_enb, s_busy, s_done, s_pass;
   logic [7:0] s_a, s_b, s_err;
   logic [1:0] s_m;

   always_comb begin
      s_enb = 1'b0; s_busy = 1'b0; s_done = 1'b0; s_pass = 1'b0;
      s_a = 8'h00; s_b = 8'h00; s_err = 8'h00; s_m = 2'b00;
      case (sel)
         1: begin s_enb = enb1; s_busy = busy1; s_done = done1; s_pass = pass1;
                  s_a = a1; s_b = b1; s_err = err1; s_m = m1; end
         3: begin s_enb = enb3; s_busy = busy3; s_done = done3; s_pass = pass3;
                  s_a = a3; s_b = b3; s_err = err3; s_m = m3; end
         5: begin s_enb = enb5; s_busy = busy5; s_done = done5; s_pass = pass5;
                  s_a = a5; s_b = b5; s_err = err5; s_m = m5; end
         7: begin s_enb = enb7; s_busy = busy7; s_done = done7; s_pass = pass7;
                  s_a = a7; s_b = b7; s_err = err7; s_m = m7; end
         default: ;
      endcase
   end

   // Expected vector stream and derived counts.
   logic [7:0] mdl_a [256];
   logic [7:0] mdl_b [256];
   logic [1:0] mdl_m [256];
   logic [7:0] cap_a [256];
   logic [7:0] cap_b [256];
   logic [1:0] cap_m [256];
   int n_resta;
   int n_zero;

   int n_enb, gap_bad, hold_bad, seq_bad, last_k;
   logic [17:0] hold_v;
   logic first_busy, first_done;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic set_start(input int id, input logic v);
      case (id)
         1: start1 = v;
         3: start3 = v;
         5: start5 = v;
         7: start7 = v;
         default: ;
      endcase
   endtask

   task automatic sample(input int k, input int period);
      logic [7:0] idx;
      if (s_enb) begin
         if (n_enb > 0 && (k - last_k) != period) gap_bad++;
         if (n_enb < 256) begin
            idx = 8'(n_enb);
            cap_a[idx] = s_a; cap_b[idx] = s_b; cap_m[idx] = s_m;
            if ({s_a, s_b, s_m} != {mdl_a[idx], mdl_b[idx], mdl_m[idx]}) seq_bad++;
         end
         last_k = k;
         n_enb++;
         hold_v = {s_a, s_b, s_m};
      end else if (s_busy && n_enb > 0 && {s_a, s_b, s_m} != hold_v) begin
         hold_bad++;
      end
   endtask

   // Pulse start, then follow the run one negedge at a time until done or limit.
   // k counts clock edges from the one that sampled start (that edge is k=1).
   task automatic do_run(input int id, input int period, input int limit,
                         input int poke_at, output int k);
      sel = id; n_enb = 0; gap_bad = 0; hold_bad = 0; seq_bad = 0; last_k = 0;
      hold_v = '0;
      @(negedge clk); set_start(id, 1'b1);
      @(negedge clk); set_start(id, 1'b0);
      k = 1;
      first_busy = s_busy;
      first_done = s_done;
      sample(k, period);
      while (!s_done && k < limit) begin
         @(negedge clk);
         k++;
         if (k == poke_at) set_start(id, 1'b1);
         else if (k == poke_at + 1) set_start(id, 1'b0);
         sample(k, period);
      end
   endtask

   initial begin
      logic [15:0] s;
      int k;
      n_chk = 0; n_pass = 0;
      rst = 1'b0; bug = 1'b0; sel = 0;
      start1 = 1'b0; start3 = 1'b0; start5 = 1'b0; start7 = 1'b0;

      s = 16'hACE1; n_resta = 0; n_zero = 0;
      for (int i = 0; i < 256; i++) begin
         mdl_a[i] = s[7:0];
         mdl_b[i] = s[15:8];
         mdl_m[i] = s[1:0] ^ s[9:8];
         if (i < 64 && mdl_m[i] == 2'b01) n_resta++;
         if (i < 255 && calc_ref(mdl_a[i], mdl_b[i], mdl_m[i]) == 8'h00) n_zero++;
         s = lfsr_step(s);
      end

      // Reset values, and start held during reset is ignored.
      repeat (3) @(negedge clk);
      chk("rst_outs1", 32'({enb1, a1, b1, m1, busy1, done1, pass1, err1}), 32'd0);
      chk("rst_outs3", 32'({enb3, a3, b3, m3, busy3, done3, pass3, err3}), 32'd0);
      start1 = 1'b1;
      @(negedge clk);
      chk("rst_wins", 32'(busy1), 32'd0);
      start1 = 1'b0;
      @(negedge clk) rst = 1'b1;

      // Reset mid-DRIVE drops enb asynchronously.
      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      chk("enb_drive", 32'(enb1), 32'd1);
      #1 rst = 1'b0;
      #1 chk("enb_async", 32'(enb1), 32'd0);
      @(negedge clk) rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_outs", 32'({enb1, a1, b1, m1, busy1, done1, pass1, err1}), 32'd0);

      // Ideal calculator, LAT=1.
      do_run(1, 2, 400, 0, k);
      chk("a_done_lat", 32'(k), 32'd129);
      chk("a_busy_first", 32'(first_busy), 32'd1);
      chk("a_n_enb", 32'(n_enb), 32'd64);
      chk("a_gap", 32'(gap_bad), 32'd0);
      chk("a_hold", 32'(hold_bad), 32'd0);
      chk("a_seq", 32'(seq_bad), 32'd0);
      chk("a_vec0", 32'({cap_a[0], cap_b[0], cap_m[0]}), 32'({8'hE1, 8'hAC, 2'b01}));
      chk("a_vec1", 32'({cap_a[1], cap_b[1], cap_m[1]}), 32'({8'h70, 8'h56, 2'b10}));
      chk("a_end", 32'({s_busy, s_done, s_pass, s_err}), 32'({1'b0, 1'b1, 1'b1, 8'h00}));

      // Restart from DONE, with a start pulse while busy.
      do_run(1, 2, 400, 10, k);
      chk("b_done_lat", 32'(k), 32'd129);
      chk("b_done_clr", 32'(first_done), 32'd0);
      chk("b_n_enb", 32'(n_enb), 32'd64);
      chk("b_seq", 32'(seq_bad), 32'd0);
      chk("b_vec0", 32'({cap_a[0], cap_b[0], cap_m[0]}), 32'({8'hE1, 8'hAC, 2'b01}));
      chk("b_end", 32'({s_done, s_pass, s_err}), 32'({1'b1, 1'b1, 8'h00}));

      // MODO 01 computes a+b.
      bug = 1'b1;
      do_run(1, 2, 400, 0, k);
      chk("c_done_lat", 32'(k), 32'd129);
      chk("c_err", 32'(s_err), 32'(n_resta));
      chk("c_pass", 32'({s_done, s_pass}), 32'({1'b1, n_resta == 0}));
      bug = 1'b0;

      // LAT=3 against a 3-stage pipeline.
      do_run(3, 4, 600, 0, k);
      chk("d_done_lat", 32'(k), 32'd257);
      chk("d_n_enb", 32'(n_enb), 32'd64);
      chk("d_gap", 32'(gap_bad), 32'd0);
      chk("d_hold", 32'(hold_bad), 32'd0);
      chk("d_seq", 32'(seq_bad), 32'd0);
      chk("d_end", 32'({s_done, s_pass, s_err}), 32'({1'b1, 1'b1, 8'h00}));

      // c stuck at zero, 255 vectors.
      do_run(5, 2, 1200, 0, k);
      chk("e_done_lat", 32'(k), 32'd511);
      chk("e_n_enb", 32'(n_enb), 32'd255);
      chk("e_seq", 32'(seq_bad), 32'd0);
      chk("e_err", 32'(s_err), 32'(255 - n_zero));
      chk("e_pass", 32'({s_done, s_pass}), 32'({1'b1, n_zero == 255}));

      // Single-vector run, LAT=2.
      do_run(7, 3, 50, 0, k);
      chk("f_done_lat", 32'(k), 32'd4);
      chk("f_n_enb", 32'(n_enb), 32'd1);
      chk("f_seq", 32'(seq_bad), 32'd0);
      chk("f_end", 32'({s_busy, s_done, s_pass, s_err}), 32'({1'b0, 1'b1, 1'b1, 8'h00}));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
